// File: rtl/mem_target.sv
// Zero-wait-state bus responder: word RAM plus I/O page (cycle counter, console TX FIFO).
// Reads are combinational, writes take one edge; the TX FIFO drains via valid/ready and drops pushes when full.
module mem_target #(
  parameter int          DEPTH      = 256,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] datai,
  input  logic        rw,
  output logic [31:0] datao,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int         AW       = $clog2(DEPTH);
  localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] FULL_CNT = 4'(FIFO_DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [7:0]    fifo_q [2**PW];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          tx_wr_q, tx_wr_d;
  logic [31:0]   cycles_q, cycles_d;

  logic sel_ram, sel_tx, sel_stat, sel_cyc;
  logic wr_en, full, empty, push, pop, push_ok;

  assign sel_ram  = address < 32'(DEPTH);
  assign sel_tx   = address == MMIO_BASE;
  assign sel_stat = address == MMIO_BASE + 32'd1;
  assign sel_cyc  = address == MMIO_BASE + 32'd2;
  assign wr_en    = ~rw;

  assign full  = count_q == FULL_CNT;
  assign empty = count_q == 4'd0;

  // A TX write held across several edges pushes only on its first edge.
  assign push    = wr_en & sel_tx & ~tx_wr_q;
  assign pop     = ~empty & tx_ready;
  assign push_ok = push & (~full | pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    tx_wr_d  = wr_en & sel_tx;
    cycles_d = cycles_q + 32'd1;

    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase

    if (push && full && !pop)              ovf_d = 1'b1;
    else if (wr_en && sel_stat && datai[5]) ovf_d = 1'b0;

    if (wr_en && sel_cyc) cycles_d = datai;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tx_wr_q  <= 1'b0;
      cycles_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tx_wr_q  <= tx_wr_d;
      cycles_q <= cycles_d;
    end
  end

  // Storage arrays carry no reset; writes are simply suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && wr_en && sel_ram) mem[address[AW-1:0]] <= datai;
    if (reset && push_ok)          fifo_q[wr_ptr_q] <= datai[7:0];
  end

  always_comb begin
    datao = '0;
    if (sel_ram)       datao = mem[address[AW-1:0]];
    else if (sel_stat) datao = {26'b0, ovf_q, empty, full, count_q[2:0]};
    else if (sel_cyc)  datao = cycles_q;
  end

  assign tx_valid = ~empty;
  assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

endmodule

// File: doc/mem_target.md
# mem_target

Bus responder for the CPU's memory port. Each cycle it serves the CPU's `address` / `datao` / `rw` request from a single-port word RAM and a small memory-mapped I/O page. The I/O page contains a free-running cycle counter and a byte-wide console transmit FIFO. The FIFO drains over a valid/ready interface to an external sink. The block sits directly opposite the CPU on the same bus and provides the data the CPU fetches and loads. The bus has no wait states.

## Interface
Parameters:
- `DEPTH`, 256: RAM size in 32-bit words; power of two; `AW = log2(DEPTH)`.
- `FIFO_DEPTH`, 4: console FIFO entries; power of two, at most 8.
- `MMIO_BASE`, 32'hFFFF_FF00: base word address of the I/O page.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; holding it at 0 forces the reset state.
- `address`  in  32  word address from the CPU.
- `datai`  in  32  write data from the CPU.
- `rw`  in  1  1 = read, 0 = write.
- `datao`  out  32  read data to the CPU (combinational).
- `tx_data`  out  8  head byte of the console FIFO.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  sink accepts `tx_data` this cycle.

## Operation
- Address decode:
  - RAM: `address < DEPTH`.
  - TX: `MMIO_BASE+0`.
  - STATUS: `MMIO_BASE+1`.
  - CYCLES: `MMIO_BASE+2`.
  - Any other address is unmapped.
- Reads are combinational from the current `address`:
  - RAM returns `mem[address[AW-1:0]]`.
  - TX returns 0.
  - STATUS returns `{26'b0, ovf, empty, full, count[2:0]}`.
  - CYCLES returns the counter value.
  - Unmapped returns 0.
- Writes happen on the rising edge of `clk` whenever `rw == 0`:
  - RAM: `mem[address[AW-1:0]] <= datai`.
  - CYCLES: counter loads `datai`.
  - STATUS: if `datai[5] == 1`, clear `ovf`; other bits are ignored.
  - Unmapped: ignored.
- TX push:
  - A push occurs on a rising edge where `rw == 0`, `address == TX`, and the previous edge was not a TX write (a registered `tx_wr_d` flag).
  - A write held low on TX for N cycles therefore pushes exactly once.
  - The pushed byte is `datai[7:0]`.
- TX pop: occurs on a rising edge where `tx_valid && tx_ready`.
- FIFO is circular with read/write pointers and a `count` of 0..`FIFO_DEPTH`.
  - `full = (count == FIFO_DEPTH)`; `empty = (count == 0)`; `tx_valid = ~empty`.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Push while full:
  - Without a same-edge pop: the byte is dropped, `ovf` is set (sticky), and `count` is unchanged.
  - With a same-edge pop: the push is accepted, there is no overflow, and `count` is unchanged.
- Simultaneous push and pop when not empty: both occur and `count` is unchanged.
- Push while empty: the byte appears on `tx_data` and `tx_valid` rises after that edge. There is no same-cycle bypass.
- Cycle counter:
  - 32-bit, increments by 1 every edge and wraps from 32'hFFFF_FFFF to 0.
  - A CYCLES write has priority over the increment on that edge.
- Reset (`reset == 0`, asynchronous):
  - Cleared: `count`, the FIFO pointers, `ovf`, `tx_wr_d`, and the counter.
  - Resulting outputs: `tx_valid = 0` and `tx_data = 0`; `datao` then reflects reset register values.
  - RAM contents are not cleared and are unchanged by reset.
  - FIFO storage is not cleared; `tx_data` is masked to 0 while the FIFO is empty.
- Reset asserted mid-burst aborts any in-progress push or pop. After release, the first TX write is treated as a fresh push.

## Timing
- Read latency is 0 cycles: `datao` is valid within the same cycle `address` is stable. This is required because the CPU captures fetch and load data on the falling clock edge.
- Write latency is 1 edge:
  - Data written on edge k is readable at `address` immediately after edge k.
  - A read of the same RAM word in the cycle before edge k returns the old value.
- STATUS and `tx_valid` update 1 edge after a push or pop.
- Pop handshake:
  - `tx_data` must hold stable while `tx_valid && !tx_ready`.
  - `tx_data` advances to the next entry on the edge where the handshake completes.
- `tx_ready` may be asserted while `tx_valid = 0`; this has no effect.
- The counter reads N+1 one edge after reading N, unless written on that edge.

## Test plan
- RAM write/read:
  - Stimulus: write 32'hDEAD_BEEF to 5 with `rw = 0` for 1 cycle, then `rw = 1` at 5.
  - Response: `datao` = 32'hDEAD_BEEF. Address 300 reads 0 and a write to 300 has no effect.
- FIFO fill and overflow:
  - Stimulus: `tx_ready = 0`; write 'A', 'B', 'C', 'D', 'E' to TX with `rw` returning to 1 between writes.
  - Response: STATUS = 6'b101100 (`ovf = 1`, `full = 1`, `count = 4`); `tx_data` = 'A'.
  - Then write 32'h20 to STATUS; response: `ovf` = 0.
- Drain:
  - Stimulus: after the fill above, hold `tx_ready = 1`.
  - Response: 'A', 'B', 'C', 'D' appear on consecutive cycles; then `tx_valid = 0` and STATUS = 6'b010000.
- Held write and simultaneous push+pop:
  - Stimulus: hold `rw = 0` at TX for 3 cycles; response: `count` = 1.
  - Stimulus: with the FIFO full and `tx_ready = 1`, push 'Z'; response: `count` stays 4, `ovf` stays 0, and 'Z' is eventually output last.
- Counter:
  - Stimulus: write 32'hFFFF_FFFE to CYCLES.
  - Response: reads give 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1 on successive cycles.
- Reset mid-operation:
  - Stimulus: 3 bytes queued and `ovf = 1`, plus RAM[7] = 9; pulse `reset` low between edges.
  - Response: immediately `tx_valid = 0` and STATUS = 6'b010000; CYCLES = 0 during reset; RAM[7] still reads 9.
